uart_frame_loader: RTL and testbench
====================================

// Module: uart_frame_loader
// PURPOSE
//  Command-frame controller that sits downstream of the UART receiver. It turns the byte stream
//  into memory writes and run requests. It detects each received byte from the receiver's
//  ready level, parses SYNC/CMD/ADDR/LEN/DATA/CSUM frames and drives a byte-wide memory write
//  port. It validates an XOR checksum and aborts on inter-byte timeout.
// PARAMETERS
//  TIMEOUT_WIDTH  16     width of inter-byte timeout counter; timeout fires when counter == all ones
//  SYNC_BYTE      8'hA5  frame start marker
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous reset, active low
//  rx_data      in   8   received byte; valid while rx_ready high
//  rx_ready     in   1   high for the stop-bit duration of each received byte
//  mem_we       out  1   one-cycle write strobe
//  mem_addr     out  8   write address
//  mem_wdata    out  8   write data
//  run_start    out  1   one-cycle pulse: RUN command accepted
//  run_addr     out  8   start address for RUN; held until next RUN
//  frame_ok     out  1   one-cycle pulse: frame completed, checksum good
//  frame_err    out  1   one-cycle pulse: frame aborted
//  err_code     out  2   0 none, 1 bad CMD, 2 bad checksum, 3 timeout; held until next ok/err
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): all outputs 0, state IDLE, counters and checksum cleared.
//    Reset mid-frame abandons the frame with no err pulse.
//  - Byte strobe: byte_stb = rx_ready & ~rx_ready_q (rx_ready_q registered, reset 0).
//    rx_data is captured in the byte_stb cycle. A level held high yields exactly one byte.
//  - Frame format: SYNC, CMD, ADDR, LEN, LEN x DATA, CSUM.
//    CSUM = XOR of CMD, ADDR, LEN and all DATA bytes.
//  - CMD 8'h01 = WRITE. CMD 8'h02 = RUN, whose LEN is ignored as 0: no DATA state, CSUM follows LEN.
//  - States and transitions, each taken on byte_stb:
//    IDLE: byte == SYNC -> CMD; any other byte is ignored, no error.
//    CMD:  01/02 -> ADDR; any other value -> IDLE with frame_err, err_code=1.
//    ADDR: -> LEN.
//    LEN:  WRITE with LEN!=0 -> DATA; otherwise -> CHECK.
//    DATA: each byte writes memory; after LEN-th byte -> CHECK.
//    CHECK: byte == running XOR -> IDLE with frame_ok (plus run_start if RUN);
//           otherwise -> IDLE with frame_err, err_code=2.
//  - Write port: mem_we pulses the cycle after a DATA byte_stb, with mem_wdata = byte and
//    mem_addr = ADDR + index. index starts at 0. Address wraps modulo 256 (ADDR 8'hFF, LEN 2 -> FF, 00).
//  - Writes are not rolled back. A bad checksum reports err but leaves memory written.
//  - frame_ok/frame_err/run_start pulse the cycle after the CSUM byte_stb.
//    run_addr updates in that same cycle.
//  - Timeout: counter clears in IDLE and on every byte_stb, increments otherwise.
//    Reaching all ones -> IDLE, frame_err, err_code=3. byte_stb in the same cycle as the
//    terminal count wins: the byte is processed and the counter clears.
//  - LEN = 0 on WRITE is legal: frame_ok, no writes.
//  - SYNC_BYTE inside a frame is ordinary data; there is no resync mid-frame.
//  - frame_ok and frame_err are never high together; at most one mem_we per byte_stb.
// TESTING
//  1. Frame A5 01 10 03 11 22 33 CS(=01^10^03^11^22^33) -> mem_we x3 at addrs 10,11,12
//     with data 11,22,33; frame_ok; err_code 0.
//  2. A5 02 40 00 42 -> run_start pulse, run_addr=40, frame_ok, no mem_we.
//  3. A5 01 FE 03 AA BB CC with bad CSUM -> writes to FE,FF,00, then frame_err, err_code=2.
//  4. A5 07 -> frame_err, err_code=1, busy low. A following valid frame is accepted normally.
//  5. A5 01 00 02 55, then silence for 2^TIMEOUT_WIDTH cycles -> frame_err, err_code=3,
//     one mem_we (addr 00, data 55).
//  6. rx_ready held high 100 cycles per byte; junk bytes 00 FF before A5; rst_n low
//     mid-DATA -> one byte per level, junk ignored, reset returns IDLE with all outputs 0.

Source files
------------

// File: rtl/uart_frame_loader.sv
// Command-frame controller behind the UART receiver: parses SYNC/CMD/ADDR/LEN/DATA/CSUM
// frames into byte memory writes and RUN requests, with XOR checksum and inter-byte timeout.
module uart_frame_loader #(
  parameter int          TIMEOUT_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       run_start,
  output logic [7:0] run_addr,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CHECK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_CMD = 2'd1, ERR_CSUM = 2'd2, ERR_TIMEOUT = 2'd3
  } err_t;

  state_t                   state_q, state_d;
  logic                     rx_ready_q;
  logic                     byte_stb;
  logic                     is_run_q;
  logic [7:0]               base_addr_q;
  logic [7:0]               len_q;
  logic [7:0]               idx_q;
  logic [7:0]               csum_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;
  logic                     tmo_hit;
  logic                     wr_d, ok_d, err_d;
  err_t                     code_d;

  assign byte_stb = rx_ready & ~rx_ready_q;
  // A byte arriving on the terminal count takes priority over the timeout.
  assign tmo_hit  = (state_q != S_IDLE) && (tmo_cnt_q == '1) && !byte_stb;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    wr_d    = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    if (byte_stb) begin
      case (state_q)
        S_IDLE:  if (rx_data == SYNC_BYTE) state_d = S_CMD;
        S_CMD: begin
          if (rx_data == CMD_WRITE || rx_data == CMD_RUN) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_CMD;
          end
        end
        S_ADDR:  state_d = S_LEN;
        S_LEN:   state_d = (!is_run_q && rx_data != 8'd0) ? S_DATA : S_CHECK;
        S_DATA: begin
          wr_d = 1'b1;
          if (8'(idx_q + 8'd1) == len_q) state_d = S_CHECK;
        end
        S_CHECK: begin
          state_d = S_IDLE;
          if (rx_data == csum_q) begin
            ok_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      is_run_q    <= 1'b0;
      base_addr_q <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      tmo_cnt_q   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      run_start   <= 1'b0;
      run_addr    <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready;

      if (state_q == S_IDLE || byte_stb) tmo_cnt_q <= '0;
      else                               tmo_cnt_q <= tmo_cnt_q + 1'b1;

      if (byte_stb) begin
        case (state_q)
          S_IDLE: begin
            csum_q <= '0;
            idx_q  <= '0;
          end
          S_CMD: begin
            is_run_q <= (rx_data == CMD_RUN);
            csum_q   <= rx_data;
          end
          S_ADDR: begin
            base_addr_q <= rx_data;
            csum_q      <= csum_q ^ rx_data;
          end
          S_LEN: begin
            len_q  <= rx_data;
            csum_q <= csum_q ^ rx_data;
          end
          S_DATA: begin
            csum_q <= csum_q ^ rx_data;
            idx_q  <= idx_q + 8'd1;
          end
          default: ;
        endcase
      end

      mem_we <= wr_d;
      if (wr_d) begin
        mem_addr  <= base_addr_q + idx_q;
        mem_wdata <= rx_data;
      end

      frame_ok  <= ok_d;
      frame_err <= err_d;
      run_start <= ok_d && is_run_q;
      if (ok_d && is_run_q) run_addr <= base_addr_q;
      if (ok_d)       err_code <= ERR_NONE;
      else if (err_d) err_code <= code_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: frame-buffer reference model checked every cycle, plus
// directed frames with hand-computed expectations and randomized frame traffic.
module tb_uart_frame_loader;

  localparam int         TW   = 8;
  localparam int         TMAX = (1 << TW) - 1;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk, rst_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       mem_we, run_start, frame_ok, frame_err, busy;
  logic [7:0] mem_addr, mem_wdata, run_addr;
  logic [1:0] err_code;

  uart_frame_loader #(.TIMEOUT_WIDTH(TW), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .run_start(run_start), .run_addr(run_addr), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the bytes of the current frame and decides from the whole
  // frame what the outputs must be on the cycle after each byte.
  logic [7:0] frame[$];
  bit         in_frame, m_prev;
  int         since;
  logic       m_we, m_ok, m_err, m_run, m_busy;
  logic [7:0] m_addr, m_wdata, m_run_addr;
  logic [1:0] m_code;

  task automatic model_step();
    bit         stb;
    int         n, total;
    logic [7:0] x;
    m_we = 0; m_ok = 0; m_err = 0; m_run = 0;
    if (!rst_n) begin
      m_prev = 0; in_frame = 0; frame.delete(); since = 0;
      m_addr = 0; m_wdata = 0; m_run_addr = 0; m_code = 0;
    end else begin
      stb    = rx_ready && !m_prev;
      m_prev = rx_ready;
      if (stb) begin
        since = 0;
        if (!in_frame) begin
          if (rx_data == SYNC) begin in_frame = 1; frame.delete(); end
        end else begin
          frame.push_back(rx_data);
          n = frame.size();
          if (n == 1 && rx_data != 8'h01 && rx_data != 8'h02) begin
            m_err = 1; m_code = 2'd1; in_frame = 0;
          end else if (n >= 4) begin
            total = (frame[0] == 8'h01) ? 4 + int'(frame[2]) : 4;
            if (n < total) begin
              m_we = 1; m_addr = 8'(frame[1] + 8'(n - 4)); m_wdata = rx_data;
            end else begin
              x = 8'h00;
              for (int i = 0; i < n - 1; i++) x = x ^ frame[i];
              if (x == rx_data) begin
                m_ok = 1; m_code = 2'd0;
                if (frame[0] == 8'h02) begin m_run = 1; m_run_addr = frame[1]; end
              end else begin
                m_err = 1; m_code = 2'd2;
              end
              in_frame = 0;
            end
          end
        end
      end else if (in_frame) begin
        if (since == TMAX) begin m_err = 1; m_code = 2'd3; in_frame = 0; end
        else since++;
      end
    end
    m_busy = in_frame;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Observation log for the directed literal expectations.
  logic [7:0] wr_addr_log[$], wr_data_log[$];
  int ok_cnt, err_cnt, run_cnt;

  initial forever begin
    @(negedge clk);
    if (mem_we === 1'b1) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
    if (frame_ok === 1'b1)  ok_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (run_start === 1'b1) run_cnt++;
    if (chk_en) begin
      check("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      check("frame_ok", 32'(frame_ok), 32'(m_ok));
      check("frame_err", 32'(frame_err), 32'(m_err));
      check("run_start", 32'(run_start), 32'(m_run));
      check("run_addr", 32'(run_addr), 32'(m_run_addr));
      check("err_code", 32'(err_code), 32'(m_code));
      check("busy", 32'(busy), 32'(m_busy));
    end
  end

  logic [7:0] tx[$];

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_tx(input int hold, input int gap);
    foreach (tx[i]) send_byte(tx[i], hold, gap);
  endtask

  function automatic logic [7:0] xor_tail();
    logic [7:0] x = 8'h00;
    for (int i = 1; i < tx.size(); i++) x = x ^ tx[i];
    return x;
  endfunction

  task automatic clear_log();
    wr_addr_log.delete(); wr_data_log.delete();
    ok_cnt = 0; err_cnt = 0; run_cnt = 0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int         kind, len, hold, gap, cut;
    logic [7:0] b;

    rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    clear_log();
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    check("reset_run_addr", 32'(run_addr), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Write frame: checksum 01^10^03^11^22^33 = 12.
    clear_log();
    tx = {SYNC, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h12};
    send_tx(2, 1); settle();
    check("t1_writes", 32'(wr_addr_log.size()), 32'd3);
    if (wr_addr_log.size() == 3) begin
      check("t1_addr0", 32'(wr_addr_log[0]), 32'h10);
      check("t1_addr2", 32'(wr_addr_log[2]), 32'h12);
      check("t1_data1", 32'(wr_data_log[1]), 32'h22);
      check("t1_data2", 32'(wr_data_log[2]), 32'h33);
    end
    check("t1_ok", 32'(ok_cnt), 32'd1);
    check("t1_err_code", 32'(err_code), 32'd0);

    // RUN frame.
    clear_log();
    tx = {SYNC, 8'h02, 8'h40, 8'h00, 8'h42};
    send_tx(1, 2); settle();
    check("t2_run", 32'(run_cnt), 32'd1);
    check("t2_run_addr", 32'(run_addr), 32'h40);
    check("t2_ok", 32'(ok_cnt), 32'd1);
    check("t2_writes", 32'(wr_addr_log.size()), 32'd0);

    // Wrapping write with a bad checksum (good would be 21).
    clear_log();
    tx = {SYNC, 8'h01, 8'hFE, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h20};
    send_tx(1, 1); settle();
    check("t3_writes", 32'(wr_addr_log.size()), 32'd3);
    if (wr_addr_log.size() == 3) begin
      check("t3_addr1", 32'(wr_addr_log[1]), 32'hFF);
      check("t3_addr2", 32'(wr_addr_log[2]), 32'h00);
      check("t3_data2", 32'(wr_data_log[2]), 32'hCC);
    end
    check("t3_err", 32'(err_cnt), 32'd1);
    check("t3_err_code", 32'(err_code), 32'd2);

    // Bad command, then a good frame.
    clear_log();
    tx = {SYNC, 8'h07};
    send_tx(1, 1); settle();
    check("t4_err_code", 32'(err_code), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_err", 32'(err_cnt), 32'd1);
    clear_log();
    tx = {SYNC, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h12};
    send_tx(1, 1); settle();
    check("t4_recover_ok", 32'(ok_cnt), 32'd1);
    check("t4_recover_code", 32'(err_code), 32'd0);

    // Timeout after one data byte.
    clear_log();
    tx = {SYNC, 8'h01, 8'h00, 8'h02, 8'h55};
    send_tx(1, 1);
    repeat (TMAX + 10) @(negedge clk);
    check("t5_err_code", 32'(err_code), 32'd3);
    check("t5_err", 32'(err_cnt), 32'd1);
    check("t5_writes", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() == 1) check("t5_data", 32'(wr_data_log[0]), 32'h55);

    // Byte landing on the terminal count is accepted: 01^20^01^77 = 57.
    clear_log();
    send_byte(SYNC, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h20, 1, 1);
    send_byte(8'h01, 1, TMAX);
    send_byte(8'h77, 1, 1); send_byte(8'h57, 1, 1); settle();
    check("tb_edge_ok", 32'(ok_cnt), 32'd1);
    check("tb_edge_writes", 32'(wr_addr_log.size()), 32'd1);
    // One cycle later the frame has already timed out.
    clear_log();
    send_byte(SYNC, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h20, 1, 1);
    send_byte(8'h01, 1, TMAX + 1);
    send_byte(8'h77, 1, 1); send_byte(8'h57, 1, 1); settle();
    check("tb_late_err_code", 32'(err_code), 32'd3);
    check("tb_late_writes", 32'(wr_addr_log.size()), 32'd0);

    // Long levels, junk before sync, reset in the middle of DATA.
    clear_log();
    tx = {8'h00, 8'hFF, SYNC, 8'h01, 8'h30, 8'h04, 8'hDE, 8'hAD};
    send_tx(100, 3);
    check("t6_writes", 32'(wr_addr_log.size()), 32'd2);
    check("t6_busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_code", 32'(err_code), 32'd0);
    check("t6_rst_mem_we", 32'(mem_we), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    check("t6_rst_wdata", 32'(mem_wdata), 32'd0);
    check("t6_rst_run_addr", 32'(run_addr), 32'd0);
    check("t6_no_pulse", 32'(ok_cnt + err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic checked cycle by cycle against the model.
    for (int f = 0; f < 120; f++) begin
      hold = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 19) == 0) ? TMAX : $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 255));
        send_byte((b == SYNC) ? 8'h00 : b, hold, 1);
      end
      kind = $urandom_range(0, 9);
      tx.delete();
      tx.push_back(SYNC);
      if (kind == 0) begin
        b = 8'($urandom_range(0, 255));
        tx.push_back((b == 8'h01 || b == 8'h02) ? 8'h80 : b);
      end else begin
        tx.push_back((kind <= 3) ? 8'h02 : 8'h01);
        tx.push_back(8'($urandom_range(0, 255)));
        len = $urandom_range(0, 5);
        tx.push_back((kind <= 3) ? 8'($urandom_range(0, 255)) : 8'(len));
        if (kind > 3) for (int i = 0; i < len; i++) tx.push_back(8'($urandom_range(0, 255)));
        b = xor_tail();
        tx.push_back(($urandom_range(0, 6) == 0) ? ~b : b);
      end
      cut = ($urandom_range(0, 11) == 0) ? $urandom_range(1, tx.size() - 1) : tx.size();
      for (int i = 0; i < cut; i++) send_byte(tx[i], hold, gap);
      if (cut != tx.size()) repeat (TMAX + 5) @(negedge clk);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
